// File: rtl/button_pulse_conditioner.sv
// Conditions two raw pushbuttons ('1' on btn1_raw, '0' on btn0_raw) into clean
// single-cycle symbol pulses for the sequence-detector FSM.
// The datapath for each channel is: synchroniser -> debounce FSM with a
// stability counter -> one-shot.
// A final registered stage arbitrates presses accepted in the same cycle.
// Parameter legality (DEBOUNCE_CYCLES >= 2, 2**CNT_W > DEBOUNCE_CYCLES,
// SYNC_STAGES >= 2) is checked outside this module.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1_raw,
    input  logic btn0_raw,
    output logic p1,
    output logic p0,
    output logic btn1_level,
    output logic btn0_level,
    output logic collision
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } chan_state_e;

    // The counter is compared against this value.
    // Reaching it while the input is still stable completes the level change.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Channel index 1 carries the '1' button and index 0 carries the '0' button.
    logic [1:0] raw_s;
    logic [1:0] accept_s;
    logic [1:0] level_s;

    assign raw_s = {btn1_raw, btn0_raw};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        chan_state_e            state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   stable_s;

        assign stable_s = sync_q[SYNC_STAGES-1];

        // Shift the asynchronous button through the synchroniser chain.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_s[g]};
            end
        end

        // The debounce FSM updates the state, the stability counter and the registered level.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= RELEASED;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
            end else begin
                case (state_q)
                    RELEASED: begin
                        level_q <= 1'b0;
                        if (stable_s) begin
                            state_q <= PRESS_CHK;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= CNT_ZERO;
                        end
                    end
                    PRESS_CHK: begin
                        if (!stable_s) begin
                            state_q <= RELEASED;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= HELD;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                            level_q <= 1'b0;
                        end
                    end
                    HELD: begin
                        level_q <= 1'b1;
                        if (!stable_s) begin
                            state_q <= RELEASE_CHK;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= CNT_ZERO;
                        end
                    end
                    RELEASE_CHK: begin
                        if (stable_s) begin
                            state_q <= HELD;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b1;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= RELEASED;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                            level_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= RELEASED;
                        cnt_q   <= CNT_ZERO;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        // Acceptance is the cycle in which the FSM commits PRESS_CHK -> HELD.
        // The output stage registers it, so the pulse coincides with the rising level.
        assign accept_s[g] = (state_q == PRESS_CHK) && stable_s && (cnt_q == CNT_LAST);
        assign level_s[g]  = level_q;
    end

    logic p1_q;
    logic p0_q;
    logic collision_q;

    // Register the arbitrated pulses.
    // If both presses are accepted in the same cycle, both are dropped and a collision is flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q        <= 1'b0;
            p0_q        <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            p1_q        <= accept_s[1] & ~accept_s[0];
            p0_q        <= accept_s[0] & ~accept_s[1];
            collision_q <= accept_s[1] & accept_s[0];
        end
    end

    assign p1         = p1_q;
    assign p0         = p0_q;
    assign collision  = collision_q;
    assign btn1_level = level_s[1];
    assign btn0_level = level_s[0];

endmodule
